// File: rtl/spiker_ctrl_pkg.sv
// Shared types and default widths for the spiker frame sequencer.
package spiker_ctrl_pkg;

  localparam int STEP_W_DEF = 8;
  localparam int TMO_W_DEF  = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_SETTLE = 3'd2,
    S_FIRE   = 3'd3,
    S_WAIT   = 3'd4,
    S_FINISH = 3'd5
  } seq_state_e;

endpackage

// File: rtl/spiker_step_watchdog.sv
// Per-timestep watchdog: limit latched on load, counter held at zero while cleared,
// expire asserted on the last allowed enabled cycle. A zero limit disables it.
module spiker_step_watchdog #(
  parameter int TMO_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [TMO_W-1:0] limit_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [TMO_W-1:0] lim_q, cnt_q;
  logic [TMO_W:0]   cnt_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lim_q <= '0;
      cnt_q <= '0;
    end else begin
      if (load_i) lim_q <= limit_i;
      if (clr_i)                     cnt_q <= '0;
      else if (en_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Counter value 0 is the first WAIT cycle, so expiring at cnt+1 == limit
  // makes the flag visible exactly 'limit' cycles after WAIT entry.
  assign cnt_nxt  = {1'b0, cnt_q} + {{TMO_W{1'b0}}, 1'b1};
  assign expire_o = en_i && (lim_q != '0) && (cnt_nxt == {1'b0, lim_q});

endmodule

// File: rtl/spiker_frame_sequencer.sv
// Frame sequencer: sample strobe, settle delay, then n_steps core timesteps via
// start/ready handshake; reports busy/done/irq and watchdog timeouts.
module spiker_frame_sequencer
  import spiker_ctrl_pkg::*;
#(
  parameter int STEP_W     = STEP_W_DEF,
  parameter int TMO_W      = TMO_W_DEF,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [STEP_W-1:0] n_steps_i,
  input  logic [TMO_W-1:0]  timeout_i,
  output logic              sample_o,
  output logic              core_start_o,
  input  logic              core_ready_i,
  input  logic              core_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [STEP_W-1:0] step_cnt_o,
  output logic              err_tmo_o,
  output logic              irq_o,
  input  logic              irq_clr_i
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  seq_state_e        state_q, state_d;
  logic [STEP_W-1:0] n_steps_q, n_steps_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              irq_q, irq_d, err_q, err_d;
  logic              irq_set, err_set;
  logic              wd_load, wd_expire, in_wait, do_abort;
  logic [STEP_W-1:0] step_inc;

  assign in_wait  = (state_q == S_WAIT);
  assign do_abort = abort_i && (state_q != S_IDLE);
  assign step_inc = (step_cnt_q == '1) ? step_cnt_q : step_cnt_q + 1'b1;

  spiker_step_watchdog #(.TMO_W(TMO_W)) u_wdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (wd_load),
    .limit_i  (timeout_i),
    .clr_i    (!in_wait),
    .en_i     (in_wait),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      n_steps_q  <= '0;
      step_cnt_q <= '0;
      settle_q   <= '0;
      irq_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_steps_q  <= n_steps_d;
      step_cnt_q <= step_cnt_d;
      settle_q   <= settle_d;
      irq_q      <= irq_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    n_steps_d    = n_steps_q;
    step_cnt_d   = step_cnt_q;
    settle_d     = settle_q;
    irq_set      = 1'b0;
    err_set      = 1'b0;
    wd_load      = 1'b0;
    sample_o     = 1'b0;
    core_start_o = 1'b0;
    done_o       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_SAMPLE;
          n_steps_d  = (n_steps_i == '0) ? {{(STEP_W-1){1'b0}}, 1'b1} : n_steps_i;
          step_cnt_d = '0;
          wd_load    = 1'b1;
        end
      end
      S_SAMPLE: begin
        sample_o = 1'b1;
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SET_LAST) state_d  = S_FIRE;
        else                      settle_d = settle_q + 1'b1;
      end
      S_FIRE: begin
        core_start_o = 1'b1;
        if (core_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done landing on the expiry cycle still counts as a completed step.
        if (core_done_i) begin
          step_cnt_d = step_inc;
          state_d    = (step_inc == n_steps_q) ? S_FINISH : S_FIRE;
        end else if (wd_expire) begin
          err_set = 1'b1;
          irq_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FINISH: begin
        done_o  = 1'b1;
        irq_set = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything; core_start drops now so the core never sees
    // a handshake the sequencer has already walked away from.
    if (do_abort) begin
      state_d      = S_IDLE;
      step_cnt_d   = step_cnt_q;
      irq_set      = 1'b0;
      err_set      = 1'b0;
      done_o       = 1'b0;
      core_start_o = 1'b0;
    end

    irq_d = irq_set ? 1'b1 : (irq_clr_i ? 1'b0 : irq_q);
    err_d = err_set ? 1'b1 : (irq_clr_i ? 1'b0 : err_q);
  end

  assign busy_o     = (state_q != S_IDLE);
  assign step_cnt_o = step_cnt_q;
  assign err_tmo_o  = err_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_spiker_frame_sequencer.sv
// Directed bench for spiker_frame_sequencer with a small reactive core model.
module tb_spiker_frame_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i, abort_i, irq_clr_i;
  logic [7:0]  n_steps_i;
  logic [15:0] timeout_i;
  logic        sample_o, core_start_o, core_ready_i, core_done_i;
  logic        busy_o, done_o, err_tmo_o, irq_o;
  logic [7:0]  step_cnt_o;

  spiker_frame_sequencer #(.STEP_W(8), .TMO_W(16), .SETTLE_CYC(2)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .n_steps_i    (n_steps_i),
    .timeout_i    (timeout_i),
    .sample_o     (sample_o),
    .core_start_o (core_start_o),
    .core_ready_i (core_ready_i),
    .core_done_i  (core_done_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .step_cnt_o   (step_cnt_o),
    .err_tmo_o    (err_tmo_o),
    .irq_o        (irq_o),
    .irq_clr_i    (irq_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // core model / monitor state
  int cyc = 0, start_cyc = 0;
  int n_sample, n_hs, n_done, run, max_run;
  int first_sample_cyc, first_hs_cyc, last_hs_cyc, err_rise_cyc;
  bit prev_err = 1'b0;
  int done_timer = 0, done_dly = 4, rdy_left = 0, rdy_wait_cfg = 0;
  bit done_en = 1'b1, ready_idle = 1'b1;

  // Core responses, driven just after each rising edge.
  initial begin
    core_ready_i = 1'b1;
    core_done_i  = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      core_done_i = 1'b0;
      if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) core_done_i = 1'b1;
      end
      if (core_start_o) begin
        if (rdy_left > 0) begin core_ready_i = 1'b0; rdy_left--; end
        else core_ready_i = 1'b1;
      end else core_ready_i = ready_idle;
    end
  end

  // Event counting on the falling edge.
  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (start_i && !busy_o) start_cyc = cyc;
      if (sample_o) begin
        n_sample++;
        if (first_sample_cyc < 0) first_sample_cyc = cyc;
      end
      if (core_start_o) begin
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (core_start_o && core_ready_i) begin
        n_hs++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        rdy_left = rdy_wait_cfg;
        if (done_en) done_timer = done_dly;
      end
      if (done_o) n_done++;
      if (err_tmo_o && !prev_err) err_rise_cyc = cyc;
      prev_err = err_tmo_o;
    end
  end

  task automatic step; @(posedge clk_i); #1; endtask
  task automatic ckp;  @(negedge clk_i); #1; endtask

  task automatic clr_mon;
    n_sample = 0; n_hs = 0; n_done = 0; run = 0; max_run = 0;
    first_sample_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1; err_rise_cyc = -1;
  endtask

  task automatic start_frame(input logic [7:0] n, input logic [15:0] t);
    step; n_steps_i = n; timeout_i = t; start_i = 1'b1;
    step; start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    do begin ckp; k++; end while (busy_o && k < budget);
    chk(tag, busy_o, 0);
  endtask

  task automatic irq_clear;
    step; irq_clr_i = 1'b1;
    step; irq_clr_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int k;
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; irq_clr_i = 1'b0;
    n_steps_i = '0; timeout_i = '0;
    clr_mon;
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_outs", {sample_o, core_start_o, done_o, err_tmo_o, irq_o}, 0);
    chk("rst_step", step_cnt_o, 0);
    step; step; rst_ni = 1'b1;

    // 1: three timesteps, ready tied high, done 4 cycles after each handshake
    clr_mon;
    start_frame(8'd3, 16'd0);
    wait_idle(80, "t1_idle");
    chk("t1_sample_lat", first_sample_cyc - start_cyc, 1);
    chk("t1_fire_lat",   first_hs_cyc - start_cyc, 4);
    chk("t1_n_sample",   n_sample, 1);
    chk("t1_n_hs",       n_hs, 3);
    chk("t1_step",       step_cnt_o, 3);
    chk("t1_n_done",     n_done, 1);
    chk("t1_irq",        irq_o, 1);
    chk("t1_err",        err_tmo_o, 0);
    irq_clear;
    chk("t1_irq_clr",    irq_o, 0);

    // 2: ready withheld 5 cycles, start must be held through the wait
    clr_mon;
    rdy_wait_cfg = 5; rdy_left = 5;
    start_frame(8'd1, 16'd0);
    wait_idle(80, "t2_idle");
    chk("t2_start_run", max_run, 6);
    chk("t2_n_hs",      n_hs, 1);
    chk("t2_step",      step_cnt_o, 1);
    chk("t2_n_done",    n_done, 1);
    rdy_wait_cfg = 0; rdy_left = 0;
    irq_clear;

    // 3: watchdog fires 10 cycles after WAIT entry
    clr_mon;
    done_en = 1'b0;
    start_frame(8'd2, 16'd10);
    wait_idle(80, "t3_idle");
    chk("t3_tmo_lat", err_rise_cyc - (last_hs_cyc + 1), 10);
    chk("t3_err",     err_tmo_o, 1);
    chk("t3_irq",     irq_o, 1);
    chk("t3_n_done",  n_done, 0);
    chk("t3_step",    step_cnt_o, 0);
    chk("t3_n_hs",    n_hs, 1);
    irq_clear;
    chk("t3_clr", {err_tmo_o, irq_o}, 0);

    // 3b: done on the expiry cycle wins over the timeout
    clr_mon;
    done_en = 1'b1; done_dly = 10;
    start_frame(8'd1, 16'd10);
    wait_idle(80, "t3b_idle");
    chk("t3b_err",    err_tmo_o, 0);
    chk("t3b_n_done", n_done, 1);
    chk("t3b_step",   step_cnt_o, 1);
    chk("t3b_irq",    irq_o, 1);
    done_dly = 4;
    irq_clear;

    // 4: abort in WAIT of step 2 of 4; start while busy is ignored
    clr_mon;
    start_frame(8'd4, 16'd0);
    step; start_i = 1'b1;
    step; start_i = 1'b0;
    k = 0;
    do begin ckp; k++; end while (step_cnt_o != 8'd1 && k < 40);
    chk("t4_reach_step1", step_cnt_o, 1);
    step; abort_i = 1'b1;
    step; abort_i = 1'b0;
    ckp;
    chk("t4_busy",  busy_o, 0);
    chk("t4_step",  step_cnt_o, 1);
    chk("t4_irq",   irq_o, 0);
    chk("t4_start", core_start_o, 0);
    repeat (6) ckp;
    chk("t4_step_hold", step_cnt_o, 1);
    chk("t4_n_done",    n_done, 0);
    chk("t4_n_sample",  n_sample, 1);
    chk("t4_irq_hold",  irq_o, 0);

    // 5: n_steps 0 runs one step; irq_clr in the FINISH cycle loses
    clr_mon;
    start_frame(8'd0, 16'd0);
    repeat (8) step;
    chk("t5_done_fin", done_o, 1);
    irq_clr_i = 1'b1;
    step; irq_clr_i = 1'b0;
    ckp;
    chk("t5_irq",    irq_o, 1);
    chk("t5_step",   step_cnt_o, 1);
    chk("t5_n_hs",   n_hs, 1);
    chk("t5_n_done", n_done, 1);
    chk("t5_busy",   busy_o, 0);
    irq_clear;

    // 6: async reset while in FIRE, then a clean frame
    clr_mon;
    rdy_wait_cfg = 20; rdy_left = 20;
    start_frame(8'd3, 16'd0);
    repeat (3) step;
    chk("t6_in_fire", core_start_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_outs", {sample_o, core_start_o, done_o, err_tmo_o, irq_o}, 0);
    chk("t6_rst_step", step_cnt_o, 0);
    step; step;
    rst_ni = 1'b1; rdy_wait_cfg = 0; rdy_left = 0;
    clr_mon;
    start_frame(8'd2, 16'd0);
    wait_idle(80, "t6_idle");
    chk("t6_n_sample", n_sample, 1);
    chk("t6_n_hs",     n_hs, 2);
    chk("t6_step",     step_cnt_o, 2);
    chk("t6_n_done",   n_done, 1);
    chk("t6_irq",      irq_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
